// File: rtl/debug_spi_transmitter_if.sv
// Push-side word interface of the debug SPI master: words in, captured MISO words out.
interface debug_spi_transmitter_if;
  logic [15:0] push_data;
  logic        push_request;
  logic        push_done;
  logic [15:0] rcvd_data;
  logic        rcvd_request;
  logic        rcvd_done;

  modport master (
    output push_data, push_request, rcvd_done,
    input  push_done, rcvd_data, rcvd_request
  );

  modport slave (
    input  push_data, push_request, rcvd_done,
    output push_done, rcvd_data, rcvd_request
  );
endinterface

// File: rtl/debug_spi_transmitter.sv
// Mode-0 SPI master standing in for the host CPU: shifts 16-bit words out MSB-first,
// returns the MISO word per transfer and keeps nCS low across back-to-back words.
module debug_spi_transmitter #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP     = 2,
  parameter int unsigned WORD_GAP     = 2,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  debug_spi_transmitter_if.slave         bus,
  output logic                           spi_ncs,
  output logic                           spi_sck,
  output logic                           spi_mosi,
  input  logic                           spi_miso
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP, S_HOLD
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          bit_q;
  logic [WORD_W-2:0]   tx_q;     // bits below the one currently on MOSI
  logic [WORD_W-1:0]   rx_q;
  logic [WORD_W-1:0]   rcvd_q;
  logic                ncs_q;
  logic                sck_q;
  logic                mosi_q;
  logic                done_q;
  logic                rreq_q;

  logic unused_rcvd_done;
  assign unused_rcvd_done = bus.rcvd_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rcvd_q  <= '0;
      ncs_q   <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rreq_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.push_request) begin
            tx_q    <= bus.push_data[WORD_W-2:0];
            mosi_q  <= bus.push_data[WORD_W-1];
            ncs_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // Rising SCK samples MISO; falling SCK presents the next MOSI bit.
        S_SHIFT: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_q <= {rx_q[WORD_W-2:0], spi_miso};
            end else begin
              bit_q <= bit_q + 4'd1;
              if (bit_q == 4'd15) begin
                mosi_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                mosi_q <= tx_q[WORD_W-2];
                tx_q   <= {tx_q[WORD_W-3:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          rreq_q  <= 1'b1;
          rcvd_q  <= rx_q;
          cnt_q   <= '0;
          state_q <= S_GAP;
        end
        // Requests are only looked at once the inter-word gap has elapsed.
        S_GAP: begin
          if (cnt_q == CNT_W'(WORD_GAP - 1)) begin
            cnt_q <= '0;
            if (bus.push_request) begin
              tx_q    <= bus.push_data[WORD_W-2:0];
              mosi_q  <= bus.push_data[WORD_W-1];
              bit_q   <= '0;
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_HOLD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.push_request) begin
            tx_q    <= bus.push_data[WORD_W-2:0];
            mosi_q  <= bus.push_data[WORD_W-1];
            bit_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end else if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            cnt_q   <= '0;
            ncs_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ncs_q   <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_ncs          = ncs_q;
  assign spi_sck          = sck_q;
  assign spi_mosi         = mosi_q;
  assign bus.push_done    = done_q;
  assign bus.rcvd_data    = rcvd_q;
  assign bus.rcvd_request = rreq_q;

endmodule

// File: tb/tb_debug_spi_transmitter.sv
// Directed bench for debug_spi_transmitter: loopback, zero MISO, back-to-back frames,
// idle timeout, mid-word reset and a shifting slave model.
module tb_debug_spi_transmitter;

  localparam int CLK_DIV      = 4;
  localparam int CS_SETUP     = 2;
  localparam int WORD_GAP     = 2;
  localparam int IDLE_TIMEOUT = 64;
  localparam int LAT_IDLE     = CS_SETUP + 32 * CLK_DIV + 2; // negedges from drive to push_done
  localparam int LAT_B2B      = WORD_GAP + 32 * CLK_DIV + 1; // push_done to push_done

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_ncs, spi_sck, spi_mosi, spi_miso;

  int miso_mode = 0;             // 0 loopback, 1 tied low, 2 slave word
  logic [15:0] slave_word = 16'h0000;
  logic [3:0]  slave_idx  = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  debug_spi_transmitter_if bus();

  debug_spi_transmitter #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .WORD_GAP(WORD_GAP), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_ncs(spi_ncs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  assign bus.rcvd_done = bus.rcvd_request;

  // Mode-0 slave: first bit valid at nCS fall, next bit after each SCK fall.
  always @(negedge spi_sck or posedge spi_ncs) begin
    if (spi_ncs) slave_idx <= 4'd0;
    else         slave_idx <= slave_idx + 4'd1;
  end

  assign spi_miso = (miso_mode == 0) ? spi_mosi :
                    (miso_mode == 1) ? 1'b0 : slave_word[4'd15 - slave_idx];

  // Drives one word and watches the bus until push_done; leaves request high if keep.
  task automatic send_word(input logic [15:0] w, input bit keep,
                           output int lat, output logic [15:0] mosi_bits,
                           output int rcvd_cnt, output logic [15:0] rcvd_val,
                           output bit ncs_rose, output bit held_bad, output bit timeout);
    logic prev_sck;
    logic [15:0] held;
    bit seen_low;
    bus.push_data    = w;
    bus.push_request = 1'b1;
    lat = 0; mosi_bits = '0; rcvd_cnt = 0; rcvd_val = '0;
    ncs_rose = 0; held_bad = 0; timeout = 1;
    prev_sck = spi_sck;
    held = bus.rcvd_data;
    seen_low = !spi_ncs;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      lat++;
      if (spi_sck && !prev_sck) mosi_bits = {mosi_bits[14:0], spi_mosi};
      prev_sck = spi_sck;
      if (!spi_ncs) seen_low = 1;
      else if (seen_low) ncs_rose = 1;
      if (bus.rcvd_request) begin
        rcvd_cnt++;
        rcvd_val = bus.rcvd_data;
      end else if (bus.rcvd_data !== held) begin
        held_bad = 1;
      end
      if (bus.push_done) begin
        timeout = 0;
        break;
      end
    end
    if (!keep) bus.push_request = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.push_request = 1'b0;
    bus.push_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (spi_ncs !== 1'b1) begin n_fail++; $display("FAIL reset_ncs: got %b expected 1", spi_ncs); end
    n_checks++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    n_checks++; if (bus.push_done !== 1'b0 || bus.rcvd_request !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got done=%b rreq=%b expected 0 0", bus.push_done, bus.rcvd_request); end
    n_checks++; if (bus.rcvd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rcvd_data: got %h expected 0000", bus.rcvd_data); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (spi_ncs !== 1'b1) begin n_fail++; $display("FAIL idle_ncs: got %b expected 1", spi_ncs); end
  endtask

  task automatic test_loopback();
    int lat, rc; logic [15:0] mb, rv; bit nr, hb, to;
    miso_mode = 0;
    send_word(16'hAC00, 0, lat, mb, rc, rv, nr, hb, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL loop_timeout: got no push_done expected push_done"); end
    n_checks++; if (lat !== LAT_IDLE) begin n_fail++; $display("FAIL loop_latency: got %0d expected %0d", lat, LAT_IDLE); end
    n_checks++; if (rc !== 1 || rv !== 16'hAC00) begin n_fail++; $display("FAIL loop_rcvd: got cnt=%0d data=%h expected 1 ac00", rc, rv); end
    n_checks++; if (mb !== 16'hAC00) begin n_fail++; $display("FAIL loop_mosi: got %h expected ac00", mb); end
  endtask

  task automatic test_zero_miso();
    int lat, rc; logic [15:0] mb, rv; bit nr, hb, to;
    miso_mode = 1;
    send_word(16'hFFA1, 0, lat, mb, rc, rv, nr, hb, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got no push_done expected push_done"); end
    n_checks++; if (mb !== 16'b1111111110100001) begin n_fail++; $display("FAIL zero_mosi_bits: got %b expected 1111111110100001", mb); end
    n_checks++; if (rc !== 1 || rv !== 16'h0000) begin n_fail++; $display("FAIL zero_rcvd: got cnt=%0d data=%h expected 1 0000", rc, rv); end
    miso_mode = 0;
  endtask

  task automatic test_back_to_back();
    int lat, rc; logic [15:0] mb, rv; bit nr, hb, to;
    logic [15:0] words [3];
    int tot_rcvd;
    words[0] = 16'hAB00; words[1] = 16'h08A2; words[2] = 16'hFFA1;
    tot_rcvd = 0;
    // Wait out any frame left open so the first word starts from IDLE.
    for (int i = 0; i < 200 && !spi_ncs; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], k != 2, lat, mb, rc, rv, nr, hb, to);
      tot_rcvd += rc;
      n_checks++; if (to || rv !== words[k]) begin n_fail++; $display("FAIL b2b_rcvd_%0d: got %h timeout=%0d expected %h", k, rv, to, words[k]); end
      n_checks++; if (mb !== words[k]) begin n_fail++; $display("FAIL b2b_mosi_%0d: got %h expected %h", k, mb, words[k]); end
      if (k > 0) begin
        n_checks++; if (lat !== LAT_B2B) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected %0d", k, lat, LAT_B2B); end
        n_checks++; if (nr) begin n_fail++; $display("FAIL b2b_ncs_%0d: got ncs rise expected ncs low", k); end
      end
    end
    n_checks++; if (tot_rcvd !== 3) begin n_fail++; $display("FAIL b2b_rcvd_count: got %0d expected 3", tot_rcvd); end
  endtask

  task automatic test_idle_timeout();
    int n, lat, rc; logic [15:0] mb, rv; bit nr, hb, to;
    // Entered right at the last push_done; HOLD starts after the gap.
    n = -1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (spi_ncs) begin n = i; break; end
    end
    n_checks++; if (n !== WORD_GAP + IDLE_TIMEOUT) begin n_fail++; $display("FAIL idle_timeout: got %0d expected %0d", n, WORD_GAP + IDLE_TIMEOUT); end
    @(negedge clk);
    send_word(16'h1234, 0, lat, mb, rc, rv, nr, hb, to);
    n_checks++; if (to || lat !== LAT_IDLE) begin n_fail++; $display("FAIL idle_resetup_latency: got %0d expected %0d", lat, LAT_IDLE); end
    n_checks++; if (rv !== 16'h1234) begin n_fail++; $display("FAIL idle_resetup_rcvd: got %h expected 1234", rv); end
  endtask

  task automatic test_reset_midword();
    int rises, lat, rc; logic [15:0] mb, rv; bit nr, hb, to, bad;
    logic prev_sck;
    for (int i = 0; i < 200 && !spi_ncs; i++) @(negedge clk);
    bus.push_data = 16'h5A5A;
    bus.push_request = 1'b1;
    rises = 0;
    prev_sck = spi_sck;
    for (int i = 0; i < 1000 && rises < 9; i++) begin
      @(negedge clk);
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
    end
    rst = 1'b1;
    bus.push_request = 1'b0;
    @(negedge clk);
    n_checks++; if (spi_ncs !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pins: got ncs=%b sck=%b mosi=%b expected 1 0 0", spi_ncs, spi_sck, spi_mosi); end
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.push_done || bus.rcvd_request) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL midrst_no_pulse: got pulse expected none"); end
    n_checks++; if (bus.rcvd_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_rcvd_data: got %h expected 0000", bus.rcvd_data); end
    send_word(16'hC3C3, 0, lat, mb, rc, rv, nr, hb, to);
    n_checks++; if (to || lat !== LAT_IDLE || rv !== 16'hC3C3 || mb !== 16'hC3C3) begin
      n_fail++; $display("FAIL midrst_clean_word: got lat=%0d rcvd=%h mosi=%h expected %0d c3c3 c3c3", lat, rv, mb, LAT_IDLE); end
  endtask

  task automatic test_slave_word();
    int lat, rc; logic [15:0] mb, rv; bit nr, hb, to;
    slave_word = 16'h02B0;
    miso_mode  = 2;
    send_word(16'h0000, 0, lat, mb, rc, rv, nr, hb, to);
    n_checks++; if (hb) begin n_fail++; $display("FAIL slave_held: got rcvd_data change before pulse expected c3c3 held"); end
    n_checks++; if (to || rc !== 1 || rv !== 16'h02B0) begin n_fail++; $display("FAIL slave_rcvd: got cnt=%0d data=%h expected 1 02b0", rc, rv); end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.rcvd_data !== 16'h02B0) begin n_fail++; $display("FAIL slave_hold_after: got %h expected 02b0", bus.rcvd_data); end
    miso_mode = 0;
  endtask

  initial begin
    bus.push_data    = '0;
    bus.push_request = 1'b0;
    test_reset();
    test_loopback();
    test_zero_miso();
    test_back_to_back();
    test_idle_timeout();
    test_reset_midword();
    test_slave_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
